// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmit and device receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_IDLE
    } tx_state_e;

    localparam int FRAME_LEN = 11;
    localparam int ACK_IDX   = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer, FILTER_LEN glitch filter and one-cycle falling-edge flag
// for one raw PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic clr_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A new level is accepted only after FILTER_LEN consecutive samples disagree with the current one.
    always_comb begin
        sync_d  = {sync_q[0], line_in};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1))
                level_d = sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter driving open-drain clock/data enables.
// Define PS2_HOST_TX_TIMEOUT_EN to include the inter-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    tx_state_e            state_q, state_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]        inh_cnt_q, inh_cnt_d;
    logic                 ack_err_q, ack_err_d;
    logic                 done_q, done_d;
    logic                 ack_pulse_q, ack_pulse_d;
    logic                 to_q, to_d;
    logic                 c_level, c_fall, d_level, d_fall_unused;
    logic                 wd_expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clock  (clock),
        .clr_n  (clr_n),
        .line_in(ps2c_in),
        .level  (c_level),
        .fall   (c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clock  (clock),
        .clr_n  (clr_n),
        .line_in(ps2d_in),
        .level  (d_level),
        .fall   (d_fall_unused)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          wd_run;

    assign wd_run     = (state_q == SEND) || (state_q == WAIT_IDLE);
    assign wd_expired = wd_run && (wd_q == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = '0;
        if (wd_run && !c_fall)
            wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        ack_err_d   = ack_err_q;
        done_d      = 1'b0;
        ack_pulse_d = 1'b0;
        to_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    // Start bit sits in the LSB so the data line always mirrors frame_q[0] in SEND.
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    inh_cnt_d = '0;
                    ack_err_d = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1))
                    state_d = REQ;
                else
                    inh_cnt_d = inh_cnt_q + 1'b1;
            end
            REQ: begin
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (c_fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'(ACK_IDX - 1)) begin
                        ack_err_d = d_level;
                        state_d   = WAIT_IDLE;
                    end else begin
                        frame_d = {1'b1, frame_q[FRAME_LEN-1:1]};
                    end
                end else if (wd_expired) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (c_level && d_level) begin
                    done_d      = 1'b1;
                    ack_pulse_d = ack_err_q;
                    state_d     = IDLE;
                end else if (wd_expired && !c_fall) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            ack_err_q   <= 1'b0;
            done_q      <= 1'b0;
            ack_pulse_q <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            ack_err_q   <= ack_err_d;
            done_q      <= done_d;
            ack_pulse_q <= ack_pulse_d;
            to_q        <= to_d;
        end
    end

    // Enables decode straight from reset-cleared state, so clr_n releases both lines at once.
    assign ps2c_oe    = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2d_oe    = (state_q == REQ) || ((state_q == SEND) && !frame_q[0]);
    assign tx_busy    = state_q != IDLE;
    assign tx_done    = done_q;
    assign tx_ack_err = ack_pulse_q;
    assign tx_timeout = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard model.
module tb_ps2_host_tx;

    localparam int H = 30;

    logic       clock = 1'b0;
    logic       clr_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_ack_err, tx_timeout;

    typedef struct {
        logic [10:0] frame;
        logic        ack;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [10:0] dev_f;
    int          inh_run = 0;
    int          inh_len = 0;
    logic        pulse_prev = 1'b0;

    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES(5000),
        .TIMEOUT_CYCLES(2000),
        .FILTER_LEN    (8)
    ) dut (
        .clock     (clock),
        .clr_n     (clr_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .ps2c_oe   (ps2c_oe),
        .ps2d_oe   (ps2d_oe),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_ack_err(tx_ack_err),
        .tx_timeout(tx_timeout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT reports an outcome.
    always @(negedge clock) begin
        if (ps2c_oe && !ps2d_oe)
            inh_run++;
        else begin
            if (ps2c_oe && ps2d_oe)
                inh_len = inh_run;
            inh_run = 0;
        end
        if (pulse_prev)
            check("pulse_width", {tx_done, tx_timeout}, 0);
        if (tx_done || tx_ack_err || tx_timeout) begin
            if (sb.size() == 0)
                check("unexpected_pulse", {tx_done, tx_ack_err, tx_timeout}, 0);
            else begin
                mon_e = sb.pop_front();
                check("outcome", {tx_done, tx_ack_err, tx_timeout}, {~mon_e.to, mon_e.ack, mon_e.to});
                if (!mon_e.to)
                    check("frame", dev_f, mon_e.frame);
                check("idle_after", {tx_busy, ps2c_oe, ps2d_oe}, 0);
            end
        end
        pulse_prev = tx_done || tx_timeout;
    end

    task automatic start_tx(input logic [7:0] d, input logic par, input logic ack, input logic to,
                            input logic push);
        exp_t x;
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        x.frame  = {1'b1, par, d, 1'b0};
        x.ack    = ack;
        x.to     = to;
        if (push)
            sb.push_back(x);
        @(negedge clock);
        tx_start = 1'b0;
        check("busy_rise", tx_busy, 1);
    endtask

    // Keyboard model: clocks n edges, samples data while clock is low, optionally ACKs on edge 11.
    task automatic device(input int n, input logic ack, input logic glitch);
        int t = 0;
        while (!(ps2d_in == 1'b0 && ps2c_oe == 1'b0) && t < 10000) begin
            @(negedge clock);
            t++;
        end
        check("req_seen", {ps2c_oe, ps2d_oe}, 2'b01);
        repeat (H) @(negedge clock);
        dev_f[0] = ps2d_in;
        for (int k = 1; k <= 10 && k <= n; k++) begin
            dev_c_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_f[k]  = ps2d_in;
            dev_c_low = 1'b0;
            if (glitch) begin
                repeat (8) @(negedge clock);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clock);
                dev_c_low = 1'b0;
                repeat (H - 11) @(negedge clock);
            end else
                repeat (H) @(negedge clock);
        end
        if (n >= 11) begin
            dev_d_low = ack;
            repeat (H / 2) @(negedge clock);
            dev_c_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_c_low = 1'b0;
            repeat (H / 2) @(negedge clock);
            dev_d_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        while (tx_busy && t < limit) begin
            @(negedge clock);
            t++;
        end
        check("busy_fall", tx_busy, 0);
    endtask

    initial begin
        tx_start = 1'b1;
        tx_data  = 8'hAA;
        repeat (3) @(negedge clock);
        check("reset_outputs", {ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_ack_err, tx_timeout}, 0);
        clr_n    = 1'b1;
        tx_start = 1'b0;
        repeat (3) @(negedge clock);
        check("start_during_reset", tx_busy, 0);

        start_tx(8'hED, 1'b1, 1'b0, 1'b0, 1'b1);
        device(11, 1'b1, 1'b0);
        wait_idle(500);

        start_tx(8'hF4, 1'b0, 1'b0, 1'b0, 1'b1);
        device(11, 1'b1, 1'b0);
        wait_idle(500);
        check("inhibit_len", inh_len, 5000);

        start_tx(8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
        device(11, 1'b0, 1'b0);
        wait_idle(500);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        start_tx(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        device(4, 1'b1, 1'b0);
        wait_idle(3000);
`else
        start_tx(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        device(4, 1'b1, 1'b0);
        repeat (3000) @(negedge clock);
        check("stuck_in_send", {tx_busy, ps2c_oe, ps2d_oe, tx_timeout}, 4'b1000);
        clr_n = 1'b0;
        @(negedge clock);
        clr_n = 1'b1;
        @(negedge clock);
        check("reset_recovers", tx_busy, 0);
`endif

        start_tx(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        device(5, 1'b1, 1'b0);
        check("busy_mid_frame", {tx_busy, ps2d_oe}, 2'b11);
        @(negedge clock);
        #2 clr_n = 1'b0;
        #1 check("async_release", {ps2c_oe, ps2d_oe, tx_busy}, 0);
        @(negedge clock);
        clr_n = 1'b1;
        repeat (5) @(negedge clock);

        start_tx(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        device(11, 1'b1, 1'b0);
        wait_idle(500);

        start_tx(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        fork
            device(11, 1'b1, 1'b1);
            for (int i = 0; i < 6; i++) begin
                repeat (900) @(negedge clock);
                if (tx_busy) begin
                    tx_data  = 8'hAB;
                    tx_start = 1'b1;
                    @(negedge clock);
                    tx_start = 1'b0;
                end
            end
        join
        wait_idle(500);
        repeat (50) @(negedge clock);
        check("no_extra_frame", {tx_busy, sb.size() == 0}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one 8-bit command byte to the keyboard, for example LED update (0xED) or reset (0xFF). It is the counterpart of the keyboard receive path and sits beside it in the I/O subsystem. It drives the shared ps2c/ps2d lines through open-drain enables. It reports completion, missing device acknowledge, and watchdog timeout. While it owns the bus, the receiver ignores line activity, gated by `tx_busy`.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low inhibit time before the request, 100 µs at 50 MHz.
- `TIMEOUT_CYCLES`, default 750000: maximum gap between device clock falling edges, 15 ms.
- `FILTER_LEN`, default 8: consecutive equal synchronized samples required to accept a line level.
- `clock` in 1: system clock. One clock domain; all logic is on the rising edge.
- `clr_n` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: byte to send. Captured when `tx_start` is accepted.
- `tx_start` in 1: single-cycle request. Accepted only in IDLE.
- `ps2c_in` in 1: raw PS/2 clock line level.
- `ps2d_in` in 1: raw PS/2 data line level.
- `ps2c_oe` out 1: 1 pulls ps2c low; 0 releases it.
- `ps2d_oe` out 1: 1 pulls ps2d low; 0 releases it.
- `tx_busy` out 1: high from acceptance until return to IDLE.
- `tx_done` out 1: one-cycle pulse at the end of every frame, including error outcomes.
- `tx_ack_err` out 1: one-cycle pulse, coincident with `tx_done`, when the device did not acknowledge.
- `tx_timeout` out 1: one-cycle pulse when the watchdog expires. `tx_done` does not pulse in this case.

## Operation
- Input conditioning:
  - Each line passes through a 2-flop synchronizer, then a FILTER_LEN glitch filter.
  - A falling edge is a filtered 1→0 transition, flagged for one cycle.
- Frame content: shift register holds {stop=1, parity, tx_data}, sent LSB first. Parity is odd: parity = ~^tx_data.
- State machine:
  - **IDLE**: both oe = 0. On `tx_start`, latch the frame, go to INHIBIT and clear the cycle counter.
  - **INHIBIT**: `ps2c_oe` = 1. After INHIBIT_CYCLES cycles, go to REQ.
  - **REQ**: exactly one cycle with `ps2c_oe` = 1 and `ps2d_oe` = 1 (start bit). Then go to SEND with `ps2c_oe` = 0 and bit_cnt = 0.
  - **SEND**: keep the current bit on the data line: `ps2d_oe` = ~bit. On each falling edge, shift out the next bit and increment bit_cnt.
    - Falling edges 1–8 present data bits 0–7.
    - Falling edge 9 presents parity.
    - Falling edge 10 presents stop: `ps2d_oe` = 0.
  - On falling edge 11, sample filtered ps2d. Low means ACK; high latches the ack-error flag. Go to WAIT_IDLE.
  - **WAIT_IDLE**: wait until filtered ps2c and ps2d are both high. Then pulse `tx_done` (plus `tx_ack_err` if flagged) and go to IDLE.
- Watchdog:
  - Counter runs in SEND and WAIT_IDLE.
  - It reloads on entry to SEND and on every falling edge.
  - When it reaches TIMEOUT_CYCLES: set both oe = 0, pulse `tx_timeout`, go to IDLE.
- `tx_start` while busy is ignored. No queueing.

## Timing
- Reset values: `ps2c_oe` = 0, `ps2d_oe` = 0, `tx_busy` = 0, `tx_done` = 0, `tx_ack_err` = 0, `tx_timeout` = 0, state IDLE, all counters 0.
- Reset asserted mid-frame releases both lines immediately (asynchronously) and abandons the frame without any pulse.
- `tx_busy` rises on the cycle after `tx_start` is sampled. It falls on the same edge that `tx_done` or `tx_timeout` pulses.
- The data-line update lags the physical falling edge by 2 + FILTER_LEN + 1 cycles. This is far below the device's minimum clock-low half-period of 30 µs.
- `tx_start` in the same cycle as `clr_n` low: reset wins, the request is dropped.
- A falling edge and watchdog expiry in the same cycle: the edge wins and the counter reloads.

## Configuration
- `PS2_HOST_TX_TIMEOUT_EN` defined: the watchdog is present as described above.
- `PS2_HOST_TX_TIMEOUT_EN` undefined:
  - The watchdog counter is removed and `tx_timeout` is tied to 0.
  - The FSM can wait indefinitely in SEND or WAIT_IDLE; only `clr_n` recovers it.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `ps2_pkg` holds:
  - state enum (IDLE, INHIBIT, REQ, SEND, WAIT_IDLE);
  - frame length constant 11;
  - ACK bit index 11;
  - the odd-parity helper function.
- The receiver shares this package.
- Sub-module `ps2_line_filter` (synchronizer, glitch filter, falling-edge flag) is instantiated twice, once for ps2c and once for ps2d. It is reusable by the receive path.

## Test plan
- `tx_data` = 0xED with a device model that ACKs:
  - ps2d, sampled on the device's rising edges, reads start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK low on falling edge 11; `tx_done` = 1 and `tx_ack_err` = 0 after both lines are high.
- `tx_data` = 0xF4: parity bit = 0. ps2c is held low for exactly 5000 cycles before the REQ cycle.
- Device model never pulls data low at the 11th clock: `tx_done` and `tx_ack_err` pulse together for one cycle.
- Device stops clocking after 4 edges:
  - `tx_timeout` pulses 750000 cycles after the 4th edge, with both oe = 0 and `tx_busy` = 0.
  - With the macro undefined, the block stays in SEND.
- `clr_n` pulsed low during bit 5: both oe drop to 0 asynchronously and no pulse outputs fire. A new 0xFF send afterwards completes normally.
- `tx_start` repeated during a frame, plus 3-cycle glitches on ps2c: the first byte only is sent and no extra bit shifts occur.
